// File: rtl/gpio_apb_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_apb_ctrl -- 32-pad GPIO block with an APB slave port and edge interrupts
//
// Register map (word addresses, paddr[1:0] ignored):
//   0x00 IN    (RO)   synchronised pad levels
//   0x04 OUT   (RW)   pad output data
//   0x08 OE    (RW)   pad drive enable, 1 = drive
//   0x0C INTE  (RW)   per-bit interrupt enable
//   0x10 PTRIG (RW)   per-bit edge polarity, 1 = rising, 0 = falling
//   0x14 INTS  (W1C)  pending interrupt status
//   0x18 CTRL  (RW)   bit0 = global interrupt enable
//
// Ports:
//   pclk, presetn              clock, synchronous active-low reset
//   psel, penable, pwrite,
//   paddr, pwdata              APB request
//   prdata, pready, pslverr    APB response (pready only in DONE)
//   in_pad_i                   asynchronous pad inputs
//   out_pad_o, oen_padoen_o    pad data / drive enable (OUT / OE registers)
//   irq_o                      registered interrupt request
// ---------------------------------------------------------------------------
module gpio_apb_ctrl #(
    parameter int GPIO_W = 32
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [4:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [GPIO_W-1:0] in_pad_i,
    output logic [GPIO_W-1:0] out_pad_o,
    output logic [GPIO_W-1:0] oen_padoen_o,
    output logic              irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [GPIO_W-1:0] out_q,   out_d;
    logic [GPIO_W-1:0] oe_q,    oe_d;
    logic [GPIO_W-1:0] inte_q,  inte_d;
    logic [GPIO_W-1:0] ptrig_q, ptrig_d;
    logic [GPIO_W-1:0] ints_q,  ints_d;
    logic              ctrl_q,  ctrl_d;
    logic [GPIO_W-1:0] sync1_q, sync1_d;
    logic [GPIO_W-1:0] sync2_q, sync2_d;
    logic [GPIO_W-1:0] sync3_q, sync3_d;
    logic [31:0]       prdata_q,  prdata_d;
    logic              pslverr_q, pslverr_d;
    logic              irq_q,     irq_d;

    logic [2:0]        reg_idx;
    logic              addr_err;
    logic              enter_done;
    logic              commit;
    logic [31:0]       rd_val;
    logic [GPIO_W-1:0] rise, fall, ints_set, ints_clr;
    logic              unused_paddr_lsb;

    assign reg_idx          = paddr[4:2];
    assign unused_paddr_lsb = ^paddr[1:0];

    // Only word 7 (0x1C) lies beyond the map; IN is the only read-only word.
    assign addr_err   = (reg_idx == 3'd7) || (pwrite && (reg_idx == 3'd0));
    assign enter_done = (state_q == ST_WAIT) && psel;
    // The bus is held stable through DONE, so the commit uses the live request.
    assign commit     = (state_q == ST_DONE) && pwrite && !addr_err;

    // APB next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (psel && !penable) state_d = ST_SETUP;
            ST_SETUP: if (!psel) state_d = ST_IDLE;
                      else if (penable) state_d = ST_WAIT;
            ST_WAIT:  if (!psel) state_d = ST_IDLE;
                      else state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = 32'd0;
        case (reg_idx)
            3'd0:    rd_val = sync2_q;
            3'd1:    rd_val = out_q;
            3'd2:    rd_val = oe_q;
            3'd3:    rd_val = inte_q;
            3'd4:    rd_val = ptrig_q;
            3'd5:    rd_val = ints_q;
            3'd6:    rd_val = {31'd0, ctrl_q};
            default: rd_val = 32'd0;
        endcase
    end

    // Edge detection runs on the second/third synchroniser stages.
    always_comb begin
        rise     = sync2_q & ~sync3_q;
        fall     = ~sync2_q & sync3_q;
        ints_set = inte_q & ((ptrig_q & rise) | (~ptrig_q & fall));
        ints_clr = (commit && (reg_idx == 3'd5)) ? pwdata : '0;
    end

    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        inte_d    = inte_q;
        ptrig_d   = ptrig_q;
        ctrl_d    = ctrl_q;
        sync1_d   = in_pad_i;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        prdata_d  = prdata_q;
        pslverr_d = enter_done && addr_err;
        irq_d     = ctrl_q && (|ints_q);
        // Set has priority over a same-cycle W1C clear.
        ints_d    = (ints_q & ~ints_clr) | ints_set;

        if (commit) begin
            case (reg_idx)
                3'd1:    out_d   = pwdata;
                3'd2:    oe_d    = pwdata;
                3'd3:    inte_d  = pwdata;
                3'd4:    ptrig_d = pwdata;
                3'd6:    ctrl_d  = pwdata[0];
                default: ;
            endcase
        end

        // Reads and erroring transfers load prdata; valid writes leave it held.
        if (enter_done && (!pwrite || addr_err)) begin
            prdata_d = addr_err ? 32'd0 : rd_val;
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
            oe_q      <= '0;
            inte_q    <= '0;
            ptrig_q   <= '0;
            ints_q    <= '0;
            ctrl_q    <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            prdata_q  <= 32'd0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            inte_q    <= inte_d;
            ptrig_q   <= ptrig_d;
            ints_q    <= ints_d;
            ctrl_q    <= ctrl_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

    assign prdata       = prdata_q;
    assign pready       = (state_q == ST_DONE);
    assign pslverr      = pslverr_q;
    assign out_pad_o    = out_q;
    assign oen_padoen_o = oe_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_apb_ctrl -- directed bench for gpio_apb_ctrl with a reference model
// of the register file, pad pipeline and interrupt logic.
// ---------------------------------------------------------------------------
module tb_gpio_apb_ctrl;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] in_pad_i;
    logic [31:0] out_pad_o, oen_padoen_o;
    logic        irq_o;

    gpio_apb_ctrl #(.GPIO_W(32)) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .in_pad_i     (in_pad_i),
        .out_pad_o    (out_pad_o),
        .oen_padoen_o (oen_padoen_o),
        .irq_o        (irq_o)
    );

    always #5 pclk = ~pclk;

    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%08h, want 0x%08h", phase, name, act, exp);
        end
    endtask

    // Reference model. p1/p2/p3 are the pad values seen one, two and three
    // edges ago; IN shows the two-edge-old value, edges compare two vs three.
    logic [31:0] m_out = '0, m_oe = '0, m_inte = '0, m_ptrig = '0, m_ints = '0;
    logic        m_ctrl = 1'b0, m_irq = 1'b0;
    logic [31:0] p1 = '0, p2 = '0, p3 = '0;
    bit          wr_pend = 1'b0;
    logic [2:0]  wr_idx  = '0;
    logic [31:0] wr_data = '0;
    bit          busy    = 1'b0;
    bit          chk_en  = 1'b0;

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return p2;
            3'd1:    return m_out;
            3'd2:    return m_oe;
            3'd3:    return m_inte;
            3'd4:    return m_ptrig;
            3'd5:    return m_ints;
            3'd6:    return {31'd0, m_ctrl};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge pclk) begin : model_step
        logic [31:0] rise, fall, set, clr;
        if (!presetn) begin
            m_out = '0; m_oe = '0; m_inte = '0; m_ptrig = '0; m_ints = '0;
            m_ctrl = 1'b0; m_irq = 1'b0;
            p1 = '0; p2 = '0; p3 = '0;
            wr_pend = 1'b0;
        end else begin
            rise  = p2 & ~p3;
            fall  = ~p2 & p3;
            set   = m_inte & ((m_ptrig & rise) | (~m_ptrig & fall));
            m_irq = m_ctrl & (|m_ints);
            clr   = '0;
            if (wr_pend) begin
                case (wr_idx)
                    3'd1: m_out   = wr_data;
                    3'd2: m_oe    = wr_data;
                    3'd3: m_inte  = wr_data;
                    3'd4: m_ptrig = wr_data;
                    3'd5: clr     = wr_data;
                    3'd6: m_ctrl  = wr_data[0];
                    default: ;
                endcase
                wr_pend = 1'b0;
            end
            m_ints = (m_ints & ~clr) | set;
            p3 = p2; p2 = p1; p1 = in_pad_i;
        end
        chk_en = 1'b1;
    end

    // Per-cycle comparison of the always-meaningful outputs.
    always @(negedge pclk) begin
        if (chk_en) begin
            check("out_pad_o", out_pad_o, m_out);
            check("oen_padoen_o", oen_padoen_o, m_oe);
            check("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
            if (!busy) begin
                check("pready_idle", {31'd0, pready}, 32'd0);
                check("pslverr_idle", {31'd0, pslverr}, 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            @(negedge pclk);
        end
    endtask

    // One APB transfer, started and ended at a falling edge. The master sees
    // pready at the 4th rising edge after psel goes high. pad_evt = k drives
    // pad_val onto the pads just before rising edge k of the transfer.
    task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                       input int pad_evt, input logic [31:0] pad_val, output logic [31:0] rdata);
        logic [31:0] exp_rd;
        logic        err;
        err = (addr[4:2] == 3'd7) || (wr && (addr[4:2] == 3'd0));
        busy = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        if (pad_evt == 1) in_pad_i = pad_val;
        @(posedge pclk); @(negedge pclk);
        check("pready_edge1", {31'd0, pready}, 32'd0);
        penable = 1'b1;
        if (pad_evt == 2) in_pad_i = pad_val;
        @(posedge pclk); @(negedge pclk);
        check("pready_edge2", {31'd0, pready}, 32'd0);
        exp_rd = err ? 32'd0 : m_read(addr[4:2]);
        if (pad_evt == 3) in_pad_i = pad_val;
        @(posedge pclk); @(negedge pclk);
        check("pready_edge3", {31'd0, pready}, 32'd1);
        check("pslverr", {31'd0, pslverr}, {31'd0, err});
        if (!wr || err) check("prdata", prdata, exp_rd);
        if (wr && !err) begin
            wr_pend = 1'b1; wr_idx = addr[4:2]; wr_data = wdata;
        end
        @(posedge pclk); @(negedge pclk);
        check("pready_edge4", {31'd0, pready}, 32'd0);
        rdata = prdata;
        psel = 1'b0; penable = 1'b0; busy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; in_pad_i = '0;
        repeat (3) @(negedge pclk);
        presetn = 1'b1;

        phase = "reset";
        check("prdata", prdata, 32'd0);
        check("irq_o", {31'd0, irq_o}, 32'd0);
        check("out_pad_o", out_pad_o, 32'd0);
        check("oen_padoen_o", oen_padoen_o, 32'd0);
        for (int i = 0; i < 7; i++) begin
            apb(1'b0, 5'(i * 4), 32'd0, 0, 32'd0, rd);
            check("reg_after_reset", rd, 32'd0);
        end

        phase = "out_oe";
        apb(1'b1, 5'h04, 32'hA5A5_0F0F, 0, 32'd0, rd);
        check("out_lit", out_pad_o, 32'hA5A5_0F0F);
        check("oe_still_0", oen_padoen_o, 32'd0);
        apb(1'b1, 5'h08, 32'hFFFF_0000, 0, 32'd0, rd);
        check("oe_lit", oen_padoen_o, 32'hFFFF_0000);
        check("out_kept", out_pad_o, 32'hA5A5_0F0F);

        phase = "irq_rise";
        apb(1'b1, 5'h0C, 32'h8, 0, 32'd0, rd);
        apb(1'b1, 5'h10, 32'h8, 0, 32'd0, rd);
        apb(1'b1, 5'h18, 32'h1, 0, 32'd0, rd);
        idle(2);
        in_pad_i[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge pclk); @(negedge pclk);
            check("irq_latency", {31'd0, irq_o}, (k == 3) ? 32'd1 : 32'd0);
        end
        apb(1'b0, 5'h14, 32'd0, 0, 32'd0, rd);
        check("ints_lit", rd, 32'h8);
        apb(1'b0, 5'h00, 32'd0, 0, 32'd0, rd);
        check("in_lit", rd, 32'h8);
        apb(1'b1, 5'h14, 32'h8, 0, 32'd0, rd);
        check("irq_hold", {31'd0, irq_o}, 32'd1);
        idle(1);
        check("irq_clear", {31'd0, irq_o}, 32'd0);
        apb(1'b0, 5'h14, 32'd0, 0, 32'd0, rd);
        check("ints_cleared", rd, 32'd0);

        phase = "fall_trig";
        apb(1'b1, 5'h0C, 32'h0, 0, 32'd0, rd);
        apb(1'b1, 5'h10, 32'h80, 0, 32'd0, rd);
        in_pad_i[7] = 1'b1;
        idle(4);
        apb(1'b1, 5'h0C, 32'h80, 0, 32'd0, rd);
        in_pad_i[7] = 1'b0;
        idle(4);
        apb(1'b0, 5'h14, 32'd0, 0, 32'd0, rd);
        check("ints_fall_ignored", rd, 32'd0);
        apb(1'b1, 5'h10, 32'h0, 0, 32'd0, rd);
        in_pad_i[7] = 1'b1;
        idle(4);
        apb(1'b0, 5'h14, 32'd0, 0, 32'd0, rd);
        check("ints_rise_ignored", rd, 32'd0);
        in_pad_i[7] = 1'b0;
        idle(4);
        apb(1'b0, 5'h14, 32'd0, 0, 32'd0, rd);
        check("ints_fall_set", rd, 32'h80);
        check("irq_fall", {31'd0, irq_o}, 32'd1);
        apb(1'b1, 5'h14, 32'h80, 0, 32'd0, rd);
        idle(1);
        apb(1'b0, 5'h14, 32'd0, 0, 32'd0, rd);
        check("ints_w1c", rd, 32'd0);

        phase = "slverr";
        apb(1'b0, 5'h04, 32'd0, 0, 32'd0, rd);
        check("read_out_lit", rd, 32'hA5A5_0F0F);
        apb(1'b0, 5'h1C, 32'd0, 0, 32'd0, rd);
        check("bad_read_data", rd, 32'd0);
        apb(1'b1, 5'h00, 32'hDEAD_BEEF, 0, 32'd0, rd);
        check("ro_write_data", rd, 32'd0);
        for (int i = 0; i < 7; i++) begin
            apb(1'b0, 5'(i * 4), 32'd0, 0, 32'd0, rd);
            if (i == 2) check("dump_oe_lit", rd, 32'hFFFF_0000);
        end

        phase = "set_clr";
        apb(1'b1, 5'h0C, 32'h1, 0, 32'd0, rd);
        apb(1'b1, 5'h10, 32'h1, 0, 32'd0, rd);
        in_pad_i[0] = 1'b1;
        idle(4);
        apb(1'b0, 5'h14, 32'd0, 0, 32'd0, rd);
        check("ints0_set", rd, 32'h1);
        in_pad_i[0] = 1'b0;
        idle(4);
        apb(1'b1, 5'h14, 32'h1, 2, in_pad_i | 32'h1, rd);
        apb(1'b0, 5'h14, 32'd0, 0, 32'd0, rd);
        check("set_beats_clr", rd, 32'h1);
        in_pad_i[0] = 1'b0;
        idle(4);
        apb(1'b1, 5'h14, 32'h1, 0, 32'd0, rd);
        apb(1'b0, 5'h14, 32'd0, 0, 32'd0, rd);
        check("plain_clr", rd, 32'd0);

        phase = "reset_wait";
        busy = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'hFFFF_FFFF;
        @(posedge pclk); @(negedge pclk);
        penable = 1'b1;
        check("pready_setup", {31'd0, pready}, 32'd0);
        @(posedge pclk); @(negedge pclk);
        check("pready_wait", {31'd0, pready}, 32'd0);
        presetn = 1'b0;
        @(posedge pclk); @(negedge pclk);
        check("pready_reset", {31'd0, pready}, 32'd0);
        check("out_reset", out_pad_o, 32'd0);
        presetn = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge pclk); @(negedge pclk);
        check("pready_after", {31'd0, pready}, 32'd0);
        check("out_no_commit", out_pad_o, 32'd0);
        busy = 1'b0;
        apb(1'b0, 5'h04, 32'd0, 0, 32'd0, rd);
        check("out_reg_zero", rd, 32'd0);
        apb(1'b0, 5'h18, 32'd0, 0, 32'd0, rd);
        check("ctrl_reg_zero", rd, 32'd0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_apb_ctrl.md
GPIO_APB_CTRL -- requirements
Module: gpio_apb_ctrl

Interface
REQ-001 SHALL have parameter: GPIO_W, 32, pad count; fixed at 32 for this revision.
REQ-002 SHALL have port: pclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: presetn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: psel  input  1  APB select.
REQ-005 SHALL have port: penable  input  1  APB access phase.
REQ-006 SHALL have port: pwrite  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: paddr  input  5  byte address; bits [1:0] ignored.
REQ-008 SHALL have port: pwdata  input  32  write data.
REQ-009 SHALL have port: prdata  output  32  registered read data.
REQ-010 SHALL have port: pready  output  1  transfer complete.
REQ-011 SHALL have port: pslverr  output  1  transfer error; valid only with pready.
REQ-012 SHALL have port: in_pad_i  input  32  pad input levels (asynchronous).
REQ-013 SHALL have port: out_pad_o  output  32  pad output data, equal to the OUT register.
REQ-014 SHALL have port: oen_padoen_o  output  32  per-pad drive enable, 1 = drive, equal to the OE register.
REQ-015 SHALL have port: irq_o  output  1  registered interrupt request.

Function
REQ-016 SHALL use this register map: 0x00 IN (RO); 0x04 OUT (RW); 0x08 OE (RW); 0x0C INTE (RW, per-bit enable); 0x10 PTRIG (RW, 1 = rising, 0 = falling); 0x14 INTS (R/W1C); 0x18 CTRL (RW, bit0 = global IE, bits[31:1] read 0).
REQ-017 SHALL run an APB FSM with states IDLE, SETUP, WAIT and DONE.
REQ-018 SHALL make these FSM transitions: IDLE->SETUP on psel&!penable; SETUP->WAIT on psel&penable; WAIT->DONE; DONE->IDLE.
REQ-019 SHALL assert pready only in DONE, so every transfer has exactly one wait state.
REQ-020 SHALL return to IDLE from SETUP or WAIT if psel deasserts, with no register commit and no pready.
REQ-021 SHALL commit writes on the rising edge that ends DONE, so the new value is visible from the next cycle.
REQ-022 SHALL load prdata on entry to DONE and hold it until the next read loads it.
REQ-023 SHALL assert pslverr with pready for an address above 0x18 or a write to IN; such a transfer SHALL change no state and SHALL return read data 0.
REQ-024 SHALL pass in_pad_i through a 2-flop synchronizer; IN reads the second-stage value.
REQ-025 SHALL detect edges by comparing the second synchronizer stage with a third registered copy.
REQ-026 SHALL set INTS[i] when INTE[i]=1 and an edge matching PTRIG[i] is detected.
REQ-027 SHALL give this latency: a pad change sampled at edge N appears in IN after edge N+1, sets INTS after edge N+2, and asserts irq_o after edge N+3.
REQ-028 SHALL clear INTS[i] on a W1C write with pwdata[i]=1; a simultaneous set and clear on the same bit SHALL leave the bit set.
REQ-029 SHALL drive irq_o as CTRL[0] & |INTS, registered.
REQ-030 SHALL NOT clear pending INTS bits when INTE[i] is cleared; such bits only stop new sets.
REQ-031 SHALL drive out_pad_o and oen_padoen_o directly from the OUT and OE registers with no added latency.

Reset
REQ-032 SHALL, while presetn=0 at a rising edge, clear every register, the synchronizer and edge flops, prdata, pready, pslverr and irq_o to 0, and set the FSM to IDLE.
REQ-033 SHALL, on reset during SETUP, WAIT or DONE, abort the transfer with no commit and no pready in the following cycle.

Verification
REQ-034 SHALL cover: write OUT=0xA5A5_0F0F, then OE=0xFFFF_0000 -> out_pad_o=0xA5A5_0F0F and oen_padoen_o=0xFFFF_0000 from the cycle after each DONE; each transfer shows pready high for exactly 1 cycle, 4 cycles after psel rises.
REQ-035 SHALL cover: in_pad_i[3] 0->1 with INTE=0x8, PTRIG=0x8, CTRL=1 -> INTS=0x8 after 3 edges and irq_o=1 after 4; W1C 0x8 -> irq_o=0 one cycle after INTS clears.
REQ-036 SHALL cover: falling edge on bit 7 while PTRIG[7]=1 -> INTS stays 0; with PTRIG[7]=0 the same edge -> INTS=0x80.
REQ-037 SHALL cover: read 0x1C and write to 0x00 -> pslverr=1 with pready, prdata=0, and a register dump unchanged.
REQ-038 SHALL cover: new edge on bit 0 in the same cycle as a W1C of bit 0 -> INTS[0]=1 afterwards.
REQ-039 SHALL cover: presetn low during WAIT of a write of OUT=0xFFFF_FFFF -> OUT=0, no pready, and the FSM back in IDLE.
